// File: rtl/rvfi_retire_checker.sv
// Pairs DUT and reference-model retirement records in retirement order and
// compares them field by field. Each stream is buffered in its own FIFO so the
// two sources may run with arbitrary skew, bounded by DEPTH and TIMEOUT.
//
// state   | meaning
// --------+----------------------------------------------------------------
// RUN     | heads are popped and compared whenever both FIFOs hold a record
// HALTED  | entered after a mismatch when STOP_ON_MISMATCH=1; no further pops,
//         | timeout counter frozen; left only through reset
module rvfi_retire_checker #(
  parameter int XLEN             = 32,
  parameter int DEPTH            = 8,
  parameter int TIMEOUT          = 1000,
  parameter int STOP_ON_MISMATCH = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            dut_valid_i,
  input  logic [63:0]     dut_order_i,
  input  logic [XLEN-1:0] dut_pc_i,
  input  logic [31:0]     dut_insn_i,
  input  logic            dut_trap_i,
  input  logic [4:0]      dut_rd_addr_i,
  input  logic [XLEN-1:0] dut_rd_wdata_i,
  input  logic            ref_valid_i,
  input  logic [63:0]     ref_order_i,
  input  logic [XLEN-1:0] ref_pc_i,
  input  logic [31:0]     ref_insn_i,
  input  logic            ref_trap_i,
  input  logic [4:0]      ref_rd_addr_i,
  input  logic [XLEN-1:0] ref_rd_wdata_i,
  output logic            mismatch_o,
  output logic [5:0]      mismatch_fields_o,
  output logic [63:0]     mismatch_order_o,
  output logic [31:0]     match_count_o,
  output logic [31:0]     mismatch_count_o,
  output logic            overflow_o,
  output logic            timeout_o,
  output logic            halted_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [31:0]   TMO_LIM  = 32'(TIMEOUT);

  typedef struct packed {
    logic [63:0]     order;
    logic [XLEN-1:0] pc;
    logic [31:0]     insn;
    logic            trap;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_wdata;
  } rec_t;

  typedef enum logic {RUN, HALTED} state_t;

  rec_t          dut_mem_q [DEPTH];
  rec_t          ref_mem_q [DEPTH];
  logic [AW-1:0] dut_wr_q, dut_rd_q, ref_wr_q, ref_rd_q;
  logic [CW-1:0] dut_cnt_q, ref_cnt_q;
  logic [31:0]   tmo_cnt_q, tmo_cnt_d;

  state_t        state_q;
  logic          mismatch_q, overflow_q, timeout_q, halted_q;
  logic [5:0]    fields_q;
  logic [63:0]   mis_order_q;
  logic [31:0]   match_cnt_q, mis_cnt_q;

  rec_t       dut_in, ref_in, dut_head, ref_head;
  logic       dut_empty, ref_empty, dut_full, ref_full;
  logic       pop, dut_push, ref_push, dut_drop, ref_drop;
  logic [5:0] cmp_mask;

  assign dut_in = {dut_order_i, dut_pc_i, dut_insn_i, dut_trap_i, dut_rd_addr_i, dut_rd_wdata_i};
  assign ref_in = {ref_order_i, ref_pc_i, ref_insn_i, ref_trap_i, ref_rd_addr_i, ref_rd_wdata_i};

  assign dut_head  = dut_mem_q[dut_rd_q];
  assign ref_head  = ref_mem_q[ref_rd_q];
  assign dut_empty = (dut_cnt_q == '0);
  assign ref_empty = (ref_cnt_q == '0);
  assign dut_full  = (dut_cnt_q == FULL_CNT);
  assign ref_full  = (ref_cnt_q == FULL_CNT);

  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  assign pop      = (state_q == RUN) && !dut_empty && !ref_empty;
  assign dut_push = dut_valid_i && (!dut_full || pop);
  assign ref_push = ref_valid_i && (!ref_full || pop);
  assign dut_drop = dut_valid_i && dut_full && !pop;
  assign ref_drop = ref_valid_i && ref_full && !pop;

  // Field compare of the two heads; rd_wdata only matters for a real register write.
  always_comb begin
    cmp_mask    = '0;
    cmp_mask[0] = (dut_head.order   != ref_head.order);
    cmp_mask[1] = (dut_head.pc      != ref_head.pc);
    cmp_mask[2] = (dut_head.insn    != ref_head.insn);
    cmp_mask[3] = (dut_head.trap    != ref_head.trap);
    cmp_mask[4] = (dut_head.rd_addr != ref_head.rd_addr);
    cmp_mask[5] = (ref_head.rd_addr != 5'd0) && !ref_head.trap &&
                  (dut_head.rd_wdata != ref_head.rd_wdata);
  end

  // Record storage; contents need no reset because occupancy is tracked separately.
  always_ff @(posedge clk_i) begin
    if (dut_push) dut_mem_q[dut_wr_q] <= dut_in;
    if (ref_push) ref_mem_q[ref_wr_q] <= ref_in;
  end

  // FIFO pointers and occupancy for both sides.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dut_wr_q  <= '0;
      dut_rd_q  <= '0;
      dut_cnt_q <= '0;
      ref_wr_q  <= '0;
      ref_rd_q  <= '0;
      ref_cnt_q <= '0;
    end else begin
      if (dut_push) dut_wr_q <= dut_wr_q + AW'(1);
      if (ref_push) ref_wr_q <= ref_wr_q + AW'(1);
      if (pop) begin
        dut_rd_q <= dut_rd_q + AW'(1);
        ref_rd_q <= ref_rd_q + AW'(1);
      end
      case ({dut_push, pop})
        2'b10:   dut_cnt_q <= dut_cnt_q + CW'(1);
        2'b01:   dut_cnt_q <= dut_cnt_q - CW'(1);
        default: dut_cnt_q <= dut_cnt_q;
      endcase
      case ({ref_push, pop})
        2'b10:   ref_cnt_q <= ref_cnt_q + CW'(1);
        2'b01:   ref_cnt_q <= ref_cnt_q - CW'(1);
        default: ref_cnt_q <= ref_cnt_q;
      endcase
    end
  end

  // Next value of the stall counter: counts only while exactly one side waits.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == RUN) begin
      if (pop || (dut_empty && ref_empty)) begin
        tmo_cnt_d = '0;
      end else if ((dut_empty != ref_empty) && (tmo_cnt_q != '1)) begin
        tmo_cnt_d = tmo_cnt_q + 32'd1;
      end
    end
  end

  // Stall counter and sticky overflow/timeout flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt_q  <= '0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      if ((TIMEOUT > 0) && (tmo_cnt_d >= TMO_LIM)) timeout_q <= 1'b1;
      if (dut_drop || ref_drop) overflow_q <= 1'b1;
    end
  end

  // Control FSM with registered compare results and saturating counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      halted_q    <= 1'b0;
      mismatch_q  <= 1'b0;
      fields_q    <= '0;
      mis_order_q <= '0;
      match_cnt_q <= '0;
      mis_cnt_q   <= '0;
    end else begin
      mismatch_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (pop) begin
            if (cmp_mask != '0) begin
              mismatch_q  <= 1'b1;
              fields_q    <= cmp_mask;
              mis_order_q <= dut_head.order;
              if (mis_cnt_q != '1) mis_cnt_q <= mis_cnt_q + 32'd1;
              if (STOP_ON_MISMATCH != 0) begin
                state_q  <= HALTED;
                halted_q <= 1'b1;
              end
            end else begin
              if (match_cnt_q != '1) match_cnt_q <= match_cnt_q + 32'd1;
            end
          end
        end
        HALTED: begin
          halted_q <= 1'b1;
        end
        default: begin
          state_q  <= RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign mismatch_o        = mismatch_q;
  assign mismatch_fields_o = fields_q;
  assign mismatch_order_o  = mis_order_q;
  assign match_count_o     = match_cnt_q;
  assign mismatch_count_o  = mis_cnt_q;
  assign overflow_o        = overflow_q;
  assign timeout_o         = timeout_q;
  assign halted_o          = halted_q;

endmodule

// File: tb/tb_rvfi_retire_checker.sv
// Bench for rvfi_retire_checker. Stimulus is issued by one process which also
// pairs records in an abstract queue model and pushes the expected result and
// its cycle onto a scoreboard; a monitor process checks every result the DUT
// presents against the scoreboard head.
module tb_rvfi_retire_checker;

  localparam int XLEN  = 32;
  localparam int DEPTH = 8;
  localparam int TMO   = 16;

  typedef struct packed {
    logic [63:0] order;
    logic [31:0] pc;
    logic [31:0] insn;
    logic        trap;
    logic [4:0]  rd;
    logic [31:0] wd;
  } rec_t;

  typedef struct {
    rec_t r;
    int   c;
  } ent_t;

  typedef struct {
    bit          mis;
    logic [5:0]  mask;
    logic [63:0] order;
    int          c;
  } exp_t;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            dut_valid_i = 1'b0, ref_valid_i = 1'b0;
  logic [63:0]     dut_order_i = '0, ref_order_i = '0;
  logic [XLEN-1:0] dut_pc_i = '0, ref_pc_i = '0;
  logic [31:0]     dut_insn_i = '0, ref_insn_i = '0;
  logic            dut_trap_i = 1'b0, ref_trap_i = 1'b0;
  logic [4:0]      dut_rd_addr_i = '0, ref_rd_addr_i = '0;
  logic [XLEN-1:0] dut_rd_wdata_i = '0, ref_rd_wdata_i = '0;
  logic            mismatch_o;
  logic [5:0]      mismatch_fields_o;
  logic [63:0]     mismatch_order_o;
  logic [31:0]     match_count_o, mismatch_count_o;
  logic            overflow_o, timeout_o, halted_o;

  rvfi_retire_checker #(
    .XLEN(XLEN), .DEPTH(DEPTH), .TIMEOUT(TMO), .STOP_ON_MISMATCH(1)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .dut_valid_i(dut_valid_i), .dut_order_i(dut_order_i), .dut_pc_i(dut_pc_i),
    .dut_insn_i(dut_insn_i), .dut_trap_i(dut_trap_i), .dut_rd_addr_i(dut_rd_addr_i),
    .dut_rd_wdata_i(dut_rd_wdata_i),
    .ref_valid_i(ref_valid_i), .ref_order_i(ref_order_i), .ref_pc_i(ref_pc_i),
    .ref_insn_i(ref_insn_i), .ref_trap_i(ref_trap_i), .ref_rd_addr_i(ref_rd_addr_i),
    .ref_rd_wdata_i(ref_rd_wdata_i),
    .mismatch_o(mismatch_o), .mismatch_fields_o(mismatch_fields_o),
    .mismatch_order_o(mismatch_order_o), .match_count_o(match_count_o),
    .mismatch_count_o(mismatch_count_o), .overflow_o(overflow_o),
    .timeout_o(timeout_o), .halted_o(halted_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int   n_checks = 0;
  int   n_fail   = 0;
  ent_t dq[$];
  ent_t rq[$];
  exp_t sb[$];
  bit   m_halted;
  int   last_exp;
  int   exp_match, exp_mism;
  logic [31:0] prev_mc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected field mask straight from the compare rules.
  function automatic logic [5:0] exp_mask(input rec_t d, input rec_t r);
    logic [5:0] m;
    m[0] = d.order != r.order;
    m[1] = d.pc != r.pc;
    m[2] = d.insn != r.insn;
    m[3] = d.trap != r.trap;
    m[4] = d.rd != r.rd;
    m[5] = (r.rd != 0) && !r.trap && (d.wd != r.wd);
    return m;
  endfunction

  // Pair in arrival order; result lands 2 cycles after the later push, one per cycle at most.
  task automatic model_pair();
    ent_t d, r;
    int t, ec;
    logic [5:0] m;
    while (dq.size() > 0 && rq.size() > 0 && !m_halted) begin
      d  = dq.pop_front();
      r  = rq.pop_front();
      t  = (d.c > r.c) ? d.c : r.c;
      ec = (t + 2 > last_exp + 1) ? t + 2 : last_exp + 1;
      last_exp = ec;
      m = exp_mask(d.r, r.r);
      sb.push_back('{mis: (m != 0), mask: m, order: d.r.order, c: ec});
      if (m != 0) m_halted = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_model();
    dq.delete();
    rq.delete();
    sb.delete();
    m_halted = 0;
    last_exp = -100;
  endtask

  task automatic do_reset();
    dut_valid_i = 0;
    ref_valid_i = 0;
    rst_i = 1;
    clear_model();
    tick();
    tick();
    rst_i = 0;
  endtask

  task automatic drive(input bit dv, input rec_t dr, input bit rv, input rec_t rr);
    dut_valid_i = dv;
    {dut_order_i, dut_pc_i, dut_insn_i, dut_trap_i, dut_rd_addr_i, dut_rd_wdata_i} = dr;
    ref_valid_i = rv;
    {ref_order_i, ref_pc_i, ref_insn_i, ref_trap_i, ref_rd_addr_i, ref_rd_wdata_i} = rr;
    if (dv) dq.push_back('{r: dr, c: cyc});
    if (rv) rq.push_back('{r: rr, c: cyc});
    model_pair();
    tick();
    dut_valid_i = 0;
    ref_valid_i = 0;
  endtask

  task automatic idle(input int n);
    dut_valid_i = 0;
    ref_valid_i = 0;
    repeat (n) tick();
  endtask

  task automatic drain(input string name);
    idle(10);
    chk(name, 64'(sb.size()), 64'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mismatch"}, 64'(mismatch_o), 0);
    chk({tag, "_fields"}, 64'(mismatch_fields_o), 0);
    chk({tag, "_order"}, mismatch_order_o, 0);
    chk({tag, "_match_cnt"}, 64'(match_count_o), 0);
    chk({tag, "_mis_cnt"}, 64'(mismatch_count_o), 0);
    chk({tag, "_overflow"}, 64'(overflow_o), 0);
    chk({tag, "_timeout"}, 64'(timeout_o), 0);
    chk({tag, "_halted"}, 64'(halted_o), 0);
  endtask

  function automatic rec_t mk(input int k);
    rec_t r;
    r.order = 64'(k);
    r.pc    = 32'h8000_0000 + 32'(4 * k);
    r.insn  = 32'h0000_0013 | (32'(k % 32) << 7);
    r.trap  = 1'b0;
    r.rd    = 5'((k % 31) + 1);
    r.wd    = 32'(k) * 32'h111;
    return r;
  endfunction

  function automatic rec_t rnd(input int k);
    rec_t r;
    r.order = 64'(k);
    r.pc    = $urandom;
    r.insn  = $urandom;
    r.trap  = ($urandom_range(0, 7) == 0);
    r.rd    = 5'($urandom_range(0, 31));
    r.wd    = $urandom;
    return r;
  endfunction

  // Monitor: every result the DUT shows must match the scoreboard head.
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_i) begin
      prev_mc   = 0;
      exp_match = 0;
      exp_mism  = 0;
    end else if (mismatch_o || (match_count_o != prev_mc)) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got mismatch=%0d match_count=%0d expected no result (cycle %0d)",
                 mismatch_o, match_count_o, cyc);
      end else begin
        e = sb.pop_front();
        chk("result_kind", 64'(mismatch_o), 64'(e.mis));
        chk("result_cycle", 64'(cyc), 64'(e.c));
        if (e.mis) begin
          exp_mism++;
          chk("mismatch_fields", 64'(mismatch_fields_o), 64'(e.mask));
          chk("mismatch_order", mismatch_order_o, e.order);
        end else begin
          exp_match++;
        end
        chk("match_count", 64'(match_count_o), 64'(exp_match));
        chk("mismatch_count", 64'(mismatch_count_o), 64'(exp_mism));
      end
      prev_mc = match_count_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rec_t a, b;
    rec_t rd_arr [40];
    rec_t rr_arr [40];
    int p0, di, ri, inj, fld, guard;
    bit dv, rv;

    do_reset();
    chk_zero("reset");

    // Lockstep, 20 identical records.
    for (int k = 0; k < 20; k++) drive(1, mk(k), 1, mk(k));
    drain("lockstep_drain");
    chk("lockstep_match", 64'(match_count_o), 20);
    chk("lockstep_mism", 64'(mismatch_count_o), 0);

    // Skew: ref trails by 6 cycles.
    do_reset();
    for (int i = 0; i < 14; i++) drive(i < 8, mk(i), i >= 6, mk(i - 6));
    drain("skew_drain");
    chk("skew_overflow", 64'(overflow_o), 0);
    chk("skew_match", 64'(match_count_o), 8);

    // Mismatch on record 5 halts the checker.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      a = mk(k);
      b = mk(k);
      if (k == 5) a.pc = 32'h8000_0018;
      drive(1, a, 1, b);
    end
    drain("halt_drain");
    chk("halt_halted", 64'(halted_o), 1);
    chk("halt_match", 64'(match_count_o), 5);
    chk("halt_mism", 64'(mismatch_count_o), 1);
    chk("halt_fields", 64'(mismatch_fields_o), 64'h02);
    chk("halt_order", mismatch_order_o, 5);

    // x0 write data is ignored; a real rd is not.
    do_reset();
    a = mk(1); a.rd = 0; a.wd = 32'h1234;
    b = mk(1); b.rd = 0; b.wd = 32'h0;
    drive(1, a, 1, b);
    drain("x0_drain");
    chk("x0_match", 64'(match_count_o), 1);
    do_reset();
    a.rd = 3;
    b.rd = 3;
    drive(1, a, 1, b);
    drain("rd3_drain");
    chk("rd3_fields", 64'(mismatch_fields_o), 64'h20);
    chk("rd3_mism", 64'(mismatch_count_o), 1);

    // Overflow and timeout with ref idle.
    do_reset();
    p0 = cyc;
    for (int k = 0; k < 8; k++) drive(1, mk(k), 0, mk(0));
    chk("ovf_before", 64'(overflow_o), 0);
    drive(1, mk(8), 0, mk(0));
    chk("ovf_after", 64'(overflow_o), 1);
    guard = 0;
    while (cyc < p0 + 16 && guard < 100) begin
      tick();
      guard++;
    end
    chk("tmo_before", 64'(timeout_o), 0);
    tick();
    chk("tmo_after", 64'(timeout_o), 1);
    rst_i = 1;
    clear_model();
    tick();
    chk_zero("midreset");
    tick();
    rst_i = 0;

    // Randomized skew; last round injects one corrupted ref field.
    for (int round = 0; round < 3; round++) begin
      do_reset();
      inj = (round == 2) ? int'($urandom_range(5, 35)) : -1;
      fld = $urandom_range(0, 5);
      for (int k = 0; k < 40; k++) begin
        rd_arr[k] = rnd(k);
        rr_arr[k] = rd_arr[k];
        if (k == inj) begin
          case (fld)
            0: rr_arr[k].order = rr_arr[k].order + 1;
            1: rr_arr[k].pc    = rr_arr[k].pc ^ 32'h4;
            2: rr_arr[k].insn  = rr_arr[k].insn ^ 32'h1;
            3: rr_arr[k].trap  = ~rr_arr[k].trap;
            4: rr_arr[k].rd    = rr_arr[k].rd ^ 5'h1;
            default: rr_arr[k].wd = rr_arr[k].wd ^ 32'h1;
          endcase
        end
      end
      di = 0;
      ri = 0;
      guard = 0;
      while ((di < 40 || ri < 40) && guard < 400) begin
        dv = (di < 40) && (di - ri < 5) && ($urandom_range(0, 9) < 7);
        rv = (ri < 40) && (ri - di < 5) && ($urandom_range(0, 9) < 7);
        drive(dv, rd_arr[dv ? di : 0], rv, rr_arr[rv ? ri : 0]);
        if (dv) di++;
        if (rv) ri++;
        guard++;
      end
      chk("rand_progress", 64'(di + ri), 80);
      drain("rand_drain");
      chk("rand_halted", 64'(halted_o), 64'(m_halted));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rvfi_retire_checker.md
Name: rvfi_retire_checker

Overview:
- Downstream consumer of the reference model's output.
- Accepts retirement records from the DUT RVFI monitor and from the reference model output stream, buffers each side in its own FIFO, and pairs records in retirement order.
- Compares paired records field by field and reports mismatches, counts, overflow and stall-timeout status to the testbench scoreboard.
- Tolerates arbitrary skew between the two streams, bounded by FIFO depth and timeout.

Parameters:
- XLEN, 32, width of pc and rd_wdata fields.
- DEPTH, 8, entries per side FIFO; power of two, minimum 2.
- TIMEOUT, 1000, cycles one side may stay unpaired before timeout_o sets; 0 disables.
- STOP_ON_MISMATCH, 1, when 1 the block enters HALTED after the first mismatch.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- dut_valid_i  in  1  DUT retirement record valid this cycle.
- dut_order_i  in  64  DUT instruction order.
- dut_pc_i  in  XLEN  DUT pc_rdata.
- dut_insn_i  in  32  DUT instruction word.
- dut_trap_i  in  1  DUT trap flag.
- dut_rd_addr_i  in  5  DUT rd address.
- dut_rd_wdata_i  in  XLEN  DUT rd write data.
- ref_valid_i, ref_order_i, ref_pc_i, ref_insn_i, ref_trap_i, ref_rd_addr_i, ref_rd_wdata_i  in  same widths  reference model record, same meaning.
- mismatch_o  out  1  one-cycle pulse: compared pair differed.
- mismatch_fields_o  out  6  field mask of the last mismatch: [0]order [1]pc [2]insn [3]trap [4]rd_addr [5]rd_wdata.
- mismatch_order_o  out  64  DUT order of the last mismatch.
- match_count_o  out  32  matched pairs, saturating.
- mismatch_count_o  out  32  mismatched pairs, saturating.
- overflow_o  out  1  sticky: a push was dropped on a full FIFO.
- timeout_o  out  1  sticky: unpaired-stall timeout reached.
- halted_o  out  1  block is in HALTED.

Behaviour:
- Reset: synchronous, while rst_i=1. Both FIFOs empty, state RUN, all outputs 0. Reset mid-operation discards buffered records and clears sticky flags and counters.
- Push: a valid_i=1 record is written to its side FIFO at the clock edge and is visible at the head the next cycle. No backpressure: the sources cannot stall.
- Full FIFO: push is dropped and overflow_o sets, unless a pop occurs in the same cycle; then push and pop both proceed and no overflow is flagged.
- Pop/compare (RUN only): when both heads are valid, both are popped in the same cycle and the compare is registered.
- Compare results appear on the next cycle:
  - mismatch_o pulses for one cycle on a mismatch.
  - Exactly one of match_count_o or mismatch_count_o increments.
- Latency: the later record of a pair arrives at cycle N, pops at N+1, and its result is visible at N+2. Throughput is one pair per cycle.
- Compare rules:
  - order, pc, insn, trap and rd_addr are compared exactly.
  - rd_wdata is compared only when ref rd_addr != 0 and ref trap = 0; otherwise bit 5 is 0.
  - Mismatch = any mask bit set.
  - mismatch_fields_o and mismatch_order_o update only on a mismatch and hold their value otherwise.
- Counters: saturate at 32'hFFFF_FFFF and never wrap.
- Timeout counter:
  - Increments each cycle exactly one FIFO is non-empty and no pop occurs.
  - Clears on any pop, or when both FIFOs are empty.
  - When it reaches TIMEOUT (TIMEOUT>0), timeout_o sets.
- States:
  - RUN → HALTED on the cycle the mismatch result registers, if STOP_ON_MISMATCH=1.
  - HALTED: no pops. Pushes continue until the FIFO is full, then overflow rules apply. The timeout counter is frozen. halted_o=1.
  - HALTED exits only via reset.
- Simultaneous valid on both inputs with both FIFOs empty: both are pushed and compared next cycle. There is no bypass path.

Test Plan:
- Lockstep: 20 identical records on both sides every cycle, order 0..19 → match_count_o=20, mismatch_count_o=0; first match result registers 2 cycles after the first push.
- Skew: DUT sends 8 records, ref sends the same 8 starting 6 cycles later, DEPTH=8 → no overflow; match_count_o=8; each result lands 2 cycles after its ref push.
- Mismatch with halt: record 5 has ref pc=0x8000_0014, DUT pc=0x8000_0018 → single mismatch_o pulse, mismatch_fields_o=6'b000010, mismatch_order_o=5, halted_o=1, match_count_o=5; later records are not compared.
- x0 write: rd_addr=0, rd_wdata 0x1234 (DUT) vs 0x0 (ref), all else equal → counted as a match. Same stimulus with rd_addr=3 → mismatch_fields_o=6'b100000.
- Overflow and timeout: TIMEOUT=16, DEPTH=8; DUT pushes 9 records and ref stays idle → overflow_o=1 on the 9th push; timeout_o=1 sixteen cycles after the first DUT record becomes visible at the head. Assert rst_i → all outputs 0 next cycle.
